vip_mmult_axi: RTL and testbench
================================

// Module: vip_mmult_axi
// PURPOSE
//  Top-level matrix-multiply accelerator: C = A x B on NxN signed 32-bit row-major matrices.
//  An internal mmult core, an AXI4 master, fetches A and B and writes C through AXI into an
//  internal AXI slave memory instance. The memory is preloaded and checked by backdoor access.
//  a/b/c are byte base addresses in that memory. start launches one run; done reports completion.
// PARAMETERS
//  N        4    matrix dimension (N>=1); each matrix is N*N words of 4 bytes
//  ADDR_W   32   AXI address width
//  DATA_W   32   AXI data width; fixed at 32
// PORTS
//  clk    in   1   single clock, rising edge
//  rst    in   1   synchronous reset, active-low (0 = reset)
//  a      in   32  byte base address of A; sampled on start
//  b      in   32  byte base address of B; sampled on start
//  c      in   32  byte base address of C; sampled on start
//  start  in   1   1-cycle launch pulse; honoured only in IDLE
//  done   out  1   1-cycle completion pulse
// BEHAVIOUR
//  - Reset: done=0; FSM=IDLE; all AXI valid/ready outputs=0. Memory contents are not cleared.
//  - Addressing: elem(base,r,k) = base + 4*(r*N+k), little-endian.
//  - AXI: 32-bit transfers, AxSIZE=2, wstrb=4'hF, AxID=0, one transaction outstanding at a time.
//  - A VALID stays asserted, with stable payload, until its READY is seen.
//  - AWVALID and WVALID are asserted together; each completes independently.
//  - Any RRESP/BRESP is accepted and ignored.
//  - FSM states and order:
//    IDLE -> RD_A -> RD_B -> MAC -> (next k or WR) -> WR -> WR_RESP -> (next j/i or DONE) -> IDLE.
//  - Loop order is i, then j, then k. For each (i,j): acc=0; for k in 0..N-1,
//    acc += A[i][k]*B[k][j]. Multiply and accumulate wrap modulo 2^32.
//  - C[i][j] is written after BVALID of the previous C write.
//  - done is asserted the cycle after the last BRESP handshake, for exactly one cycle.
//  - Latency is defined by handshakes only. With a zero-wait slave, a run completes in
//    roughly N^3*(2 reads) + N^2 writes, each a few cycles.
//  - A and B are never written. With overlapping c, C writes follow the sequential loop
//    semantics above; no hazard protection.
//  - start while busy is ignored. start and done in the same cycle: done pulses, then the new
//    start is ignored. start must be re-issued from IDLE.
//  - rst low mid-run: FSM aborts to IDLE at the next edge, valids drop, and no done is issued.
//    C may be partially written.
//  - N=1: a single read of A, a single read of B, and a single write to C.
// CONFIGURATION
//  MMULT_BURST_EN defined:
//   - Each row of A is read once per i as one INCR burst of N beats (ARLEN=N-1) into a row buffer.
//   - Each column of B is read per (i,j) as N single beats.
//   - Results are identical to the non-burst build.
//  MMULT_BURST_EN undefined:
//   - Every operand is a single-beat read (ARLEN=0).
// STRUCTURE
//  - Package mmult_axi_pkg: state enum typedef, word/address typedefs, AXI constants
//    (SIZE_4B=3'd2, BURST_INCR=2'b01), and an addr_of(base,r,k) function.
//  - Sub-module mmult_core: the FSM and the AXI4 master port.
//  - The top instantiates mmult_core and an AXI slave memory instance named axi_vip_0.
//    The instance name is required because benches reach its memory by hierarchy
//    for backdoor access.
// TESTING (N=4, a=0x000, b=0x040, c=0x080; unwritten memory reads 0xFFFFFFFF)
//  1. A=I, B[r][k]=r*4+k; pulse start -> done once; C==B; A and B unchanged.
//  2. A[r][k]=B[r][k]=1 -> every C word == 4; bytes 0x80..0xBF == 04 00 00 00 repeated.
//  3. A=all -1 (0xFFFFFFFF), B=I -> C == all 0xFFFFFFFF; 0x7FFFFFFF*2 cases wrap to 0xFFFFFFFE.
//  4. rst held low 5 cycles, then start -> done=0 during reset. After done,
//     a second start with c=0x100 writes the new area and leaves 0x080 intact.
//  5. start pulsed again 3 cycles into a run -> exactly one done; C identical to test 1.
//  6. rst low mid-run, then a fresh start -> no done from the aborted run; final C correct.
//     Repeat with and without MMULT_BURST_EN; memory images must match.

Source files
------------

// File: rtl/mmult_axi_pkg.sv
// Shared types, AXI constants and address helper for the matrix-multiply accelerator.
package mmult_axi_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam logic [2:0]  SIZE_4B    = 3'd2;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [3:0]  STRB_ALL   = 4'hF;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [31:0]       addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR,
        S_WR_RESP,
        S_DONE
    } state_t;

    // Byte address of element (r,k) of an n x n row-major word matrix.
    function automatic addr_t addr_of(input addr_t base, input int unsigned r,
                                      input int unsigned k, input int unsigned n);
        return base + addr_t'(4 * (r * n + k));
    endfunction

endpackage

// File: rtl/mmult_axi_if.sv
// AXI4 bus between the mmult core (master) and the on-chip memory (slave).
interface mmult_axi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/mmult_axi_mem.sv
// Word-addressed AXI4 slave memory; contents survive reset and are reached by hierarchy as r_mem.
module mmult_axi_mem #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input logic clk,
    input logic rst,
    mmult_axi_if.slave s_axi
);
    localparam int unsigned MEM_AW = $clog2(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_raddr, r_waddr;
    logic [7:0]        r_rcnt;
    logic [31:0]       r_rdata, r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_arready, r_rd_busy, r_rvalid, r_rlast;
    logic              r_awready, r_aw_have, r_wready, r_w_have, r_bvalid;
    logic              w_wr_fire, w_unused;

    assign w_wr_fire = r_aw_have & r_w_have;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_arready <= 1'b0;
            r_rd_busy <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_awready <= 1'b0;
            r_aw_have <= 1'b0;
            r_wready  <= 1'b0;
            r_w_have  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            if (!r_rd_busy && !r_arready && s_axi.arvalid) r_arready <= 1'b1;
            if (r_arready && s_axi.arvalid) begin
                r_arready <= 1'b0;
                r_rd_busy <= 1'b1;
                r_raddr   <= s_axi.araddr;
                r_rcnt    <= s_axi.arlen;
            end
            if (r_rd_busy && !r_rvalid) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_mem[r_raddr[MEM_AW+1:2]];
                r_rlast  <= (r_rcnt == 8'd0);
            end
            // Each beat is re-fetched after its handshake so RDATA always tracks r_raddr
            if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
                if (r_rlast) begin
                    r_rd_busy <= 1'b0;
                end else begin
                    r_raddr <= r_raddr + ADDR_W'(4);
                    r_rcnt  <= r_rcnt - 8'd1;
                end
            end

            if (!r_aw_have && !r_awready && !r_bvalid && s_axi.awvalid) r_awready <= 1'b1;
            if (r_awready && s_axi.awvalid) begin
                r_awready <= 1'b0;
                r_aw_have <= 1'b1;
                r_waddr   <= s_axi.awaddr;
            end
            if (!r_w_have && !r_wready && !r_bvalid && s_axi.wvalid) r_wready <= 1'b1;
            if (r_wready && s_axi.wvalid) begin
                r_wready <= 1'b0;
                r_w_have <= 1'b1;
                r_wdata  <= s_axi.wdata;
                r_wstrb  <= s_axi.wstrb;
            end
            if (w_wr_fire) begin
                r_aw_have <= 1'b0;
                r_w_have  <= 1'b0;
                r_bvalid  <= 1'b1;
            end
            if (r_bvalid && s_axi.bready) r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_wr_fire) begin
            for (int unsigned bb = 0; bb < 4; bb++) begin
                if (r_wstrb[bb]) r_mem[r_waddr[MEM_AW+1:2]][bb*8 +: 8] <= r_wdata[bb*8 +: 8];
            end
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rid     = '0;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = '0;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bid     = '0;
    assign s_axi.bresp   = '0;
    assign s_axi.bvalid  = r_bvalid;

    assign w_unused = ^{s_axi.arid, s_axi.arsize, s_axi.arburst, s_axi.awid, s_axi.awlen,
                        s_axi.awsize, s_axi.awburst, s_axi.wlast,
                        r_raddr[ADDR_W-1:MEM_AW+2], r_raddr[1:0],
                        r_waddr[ADDR_W-1:MEM_AW+2], r_waddr[1:0]};

endmodule

// File: rtl/mmult_core.sv
// Matrix-multiply FSM and AXI4 master: C[i][j] = sum_k A[i][k]*B[k][j], one transaction at a time.
// MMULT_BURST_EN: fetch each row of A once per i as an N-beat INCR burst into a row buffer.
module mmult_core
    import mmult_axi_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t i_a,
    input  addr_t i_b,
    input  addr_t i_c,
    input  logic  i_start,
    output logic  o_done,
    mmult_axi_if.master m_axi
);
    localparam int unsigned    IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
`ifdef MMULT_BURST_EN
    localparam logic [7:0] A_LEN = 8'(N - 1);
`else
    localparam logic [7:0] A_LEN = 8'd0;
`endif

    state_t            r_state;
    addr_t             r_a, r_b, r_c;
    logic [IDX_W-1:0]  r_i, r_j, r_k;
    word_t             r_acc, r_opb, r_wdata;
    logic [ADDR_W-1:0] r_araddr, r_awaddr;
    logic [7:0]        r_arlen;
    logic              r_done, r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    word_t             w_opa, w_sum;
    logic [IDX_W-1:0]  w_ni, w_nj, w_nk;
    logic              w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_unused;

`ifdef MMULT_BURST_EN
    word_t             r_row [N];
    logic [IDX_W-1:0]  r_beat;
    assign w_opa = r_row[r_k];
`else
    word_t             r_opa;
    assign w_opa = r_opa;
`endif

    assign w_ar_hs = r_arvalid & m_axi.arready;
    assign w_r_hs  = m_axi.rvalid & r_rready;
    assign w_aw_hs = r_awvalid & m_axi.awready;
    assign w_w_hs  = r_wvalid & m_axi.wready;
    assign w_b_hs  = m_axi.bvalid & r_bready;
    assign w_sum   = r_acc + w_opa * r_opb;
    assign w_nk    = r_k + IDX_W'(1);
    assign w_ni    = (r_j == LAST) ? r_i + IDX_W'(1) : r_i;
    assign w_nj    = (r_j == LAST) ? '0 : r_j + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_ar_hs) r_arvalid <= 1'b0;
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a       <= i_a;
                        r_b       <= i_b;
                        r_c       <= i_c;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                        r_acc     <= '0;
`ifdef MMULT_BURST_EN
                        r_beat    <= '0;
`endif
                        r_araddr  <= ADDR_W'(i_a);
                        r_arlen   <= A_LEN;
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    if (w_r_hs) begin
`ifdef MMULT_BURST_EN
                        r_row[r_beat] <= m_axi.rdata;
                        r_beat        <= (r_beat == LAST) ? '0 : r_beat + IDX_W'(1);
                        if (r_beat == LAST) begin
`else
                        r_opa <= m_axi.rdata;
                        begin
`endif
                            r_araddr  <= ADDR_W'(addr_of(r_b, 32'(r_k), 32'(r_j), N));
                            r_arlen   <= 8'd0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_B;
                        end
                    end
                end
                S_RD_B: begin
                    if (w_r_hs) begin
                        r_opb    <= m_axi.rdata;
                        r_rready <= 1'b0;
                        r_state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (r_k == LAST) begin
                        r_awaddr  <= ADDR_W'(addr_of(r_c, 32'(r_i), 32'(r_j), N));
                        r_wdata   <= w_sum;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WR;
                    end else begin
                        r_acc     <= w_sum;
                        r_k       <= w_nk;
                        r_arlen   <= 8'd0;
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
`ifdef MMULT_BURST_EN
                        r_araddr  <= ADDR_W'(addr_of(r_b, 32'(w_nk), 32'(r_j), N));
                        r_state   <= S_RD_B;
`else
                        r_araddr  <= ADDR_W'(addr_of(r_a, 32'(r_i), 32'(w_nk), N));
                        r_state   <= S_RD_A;
`endif
                    end
                end
                S_WR: begin
                    if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_acc    <= '0;
                        r_k      <= '0;
                        if (r_i == LAST && r_j == LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_i       <= w_ni;
                            r_j       <= w_nj;
                            r_arvalid <= 1'b1;
                            r_rready  <= 1'b1;
`ifdef MMULT_BURST_EN
                            // A new row of A is needed only when j wraps
                            if (r_j == LAST) begin
                                r_araddr <= ADDR_W'(addr_of(r_a, 32'(w_ni), 32'(0), N));
                                r_arlen  <= A_LEN;
                                r_state  <= S_RD_A;
                            end else begin
                                r_araddr <= ADDR_W'(addr_of(r_b, 32'(0), 32'(w_nj), N));
                                r_arlen  <= 8'd0;
                                r_state  <= S_RD_B;
                            end
`else
                            r_araddr  <= ADDR_W'(addr_of(r_a, 32'(w_ni), 32'(0), N));
                            r_arlen   <= 8'd0;
                            r_state   <= S_RD_A;
`endif
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_done        = r_done;
    assign m_axi.arid    = '0;
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = r_arlen;
    assign m_axi.arsize  = SIZE_4B;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;
    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = SIZE_4B;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = STRB_ALL;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;

    // Responses are accepted and ignored; bursts are counted by beats rather than RLAST.
    assign w_unused = ^{m_axi.rid, m_axi.rresp, m_axi.rlast, m_axi.bid, m_axi.bresp};

endmodule

// File: rtl/vip_mmult_axi.sv
// Matrix-multiply accelerator top: mmult core mastering AXI into the axi_vip_0 memory.
// Optional build macro MMULT_BURST_EN selects burst reads of A rows (results unchanged).
module vip_mmult_axi
    import mmult_axi_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t a,
    input  addr_t b,
    input  addr_t c,
    input  logic  start,
    output logic  done
);
    mmult_axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) w_axi ();

    mmult_core #(.N(N), .ADDR_W(ADDR_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_a     (a),
        .i_b     (b),
        .i_c     (c),
        .i_start (start),
        .o_done  (done),
        .m_axi   (w_axi)
    );

    mmult_axi_mem #(.ADDR_W(ADDR_W), .DEPTH(256)) axi_vip_0 (
        .clk   (clk),
        .rst   (rst),
        .s_axi (w_axi)
    );

endmodule

// File: tb/tb_vip_mmult_axi.sv
// Self-checking bench for vip_mmult_axi: backdoor-loaded matrices, plain-loop reference model.
module tb_vip_mmult_axi;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [31:0] a, b, c;

    vip_mmult_axi #(.N(N)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .start(start), .done(done)
    );

    always #5 clk = ~clk;

    int          vectors      = 0;
    int          miscompares  = 0;
    int          done_cnt     = 0;
    bit          done_allowed = 1'b0;
    logic [31:0] model [DEPTH];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // One clock: done may only pulse once per launched run and never otherwise.
    task automatic tick();
        @(negedge clk);
        vectors++;
        if (done === 1'b1 && !done_allowed) begin
            miscompares++;
            $display("FAIL done_unexpected: got done=1 want 0 at %0t", $time);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_allowed = 1'b0;
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        dut.axi_vip_0.r_mem[idx] = v;
        model[idx] = v;
    endtask

    function automatic logic [31:0] peek(input int idx);
        return dut.axi_vip_0.r_mem[idx];
    endfunction

    // kind: 0 = p on diagonal, 1 = r*N+k, 2 = all p, 3 = random
    task automatic load_mat(input logic [31:0] base, input int kind, input logic [31:0] p);
        logic [31:0] v;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                case (kind)
                    0:       v = (r == k) ? p : 32'd0;
                    1:       v = 32'(r * N + k);
                    2:       v = p;
                    default: v = $urandom();
                endcase
                poke(int'(base >> 2) + r * N + k, v);
            end
        end
    endtask

    task automatic model_run(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [31:0] acc;
                acc = 32'd0;
                for (int k = 0; k < N; k++)
                    acc = acc + model[int'(aa >> 2) + i * N + k] * model[int'(bb >> 2) + k * N + j];
                model[int'(cc >> 2) + i * N + j] = acc;
            end
        end
    endtask

    task automatic check_mem(input string name);
        int shown = 0;
        for (int idx = 0; idx < DEPTH; idx++) begin
            vectors++;
            if (peek(idx) !== model[idx]) begin
                miscompares++;
                if (shown < 16)
                    $display("FAIL %s word %0d: got 0x%08h want 0x%08h", name, idx, peek(idx), model[idx]);
                shown++;
            end
        end
    endtask

    task automatic run(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc,
                       input int restart_at, input bit start_on_done);
        int cnt0;
        int t;
        a = aa; b = bb; c = cc;
        start = 1'b1;
        done_allowed = 1'b1;
        cnt0 = done_cnt;
        tick();
        t = 0;
        while (done_cnt == cnt0 && t < 20000) begin
            start = (restart_at != 0 && t == restart_at);
            tick();
            t++;
        end
        start = 1'b0;
        check("done_seen", 32'(done_cnt - cnt0), 32'd1);
        if (start_on_done) begin
            c = 32'h200;
            start = 1'b1;
            tick();
            start = 1'b0;
            c = cc;
            repeat (300) tick();
        end else begin
            repeat (5) tick();
        end
        model_run(aa, bb, cc);
        check_mem("mem_image");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
        tick();
        for (int idx = 0; idx < DEPTH; idx++) poke(idx, 32'hFFFF_FFFF);

        // Held reset with a start pulse: nothing may launch, done stays low.
        for (int n = 0; n < 5; n++) begin
            start = (n == 2);
            tick();
            check("reset_done_low", 32'(done), 32'd0);
        end
        start = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // Identity A: C must equal B.
        load_mat(32'h000, 0, 32'd1);
        load_mat(32'h040, 1, 32'd0);
        run(32'h000, 32'h040, 32'h080, 0, 1'b0);
        check("t1_c12", peek(32 + 1 * 4 + 2), 32'd6);
        check("t1_c33", peek(32 + 15), 32'd15);
        check("t1_a11", peek(5), 32'd1);

        // All ones: every C word is 4, i.e. bytes 04 00 00 00.
        load_mat(32'h000, 2, 32'd1);
        load_mat(32'h040, 2, 32'd1);
        run(32'h000, 32'h040, 32'h080, 0, 1'b0);
        check("t2_c00", peek(32), 32'h0000_0004);
        check("t2_c31_byte0", peek(32 + 13) & 32'hFF, 32'h04);

        // A all -1, B = I: C all -1.
        load_mat(32'h000, 2, 32'hFFFF_FFFF);
        load_mat(32'h040, 0, 32'd1);
        run(32'h000, 32'h040, 32'h080, 0, 1'b0);
        check("t3_c00", peek(32), 32'hFFFF_FFFF);
        check("t3_c23", peek(32 + 11), 32'hFFFF_FFFF);

        // 0x7FFFFFFF * 2 wraps to 0xFFFFFFFE.
        load_mat(32'h000, 0, 32'h7FFF_FFFF);
        load_mat(32'h040, 0, 32'd2);
        run(32'h000, 32'h040, 32'h080, 0, 1'b0);
        check("t3_wrap_c22", peek(32 + 10), 32'hFFFF_FFFE);
        check("t3_wrap_c01", peek(32 + 1), 32'd0);

        // Second run into 0x100 leaves the 0x080 result intact.
        load_mat(32'h040, 0, 32'd1);
        run(32'h000, 32'h040, 32'h100, 0, 1'b0);
        check("t4_new_c00", peek(64), 32'h7FFF_FFFF);
        check("t4_old_c00", peek(32), 32'hFFFF_FFFE);

        // start re-pulsed 3 cycles into a run: one done, identity result.
        load_mat(32'h000, 0, 32'd1);
        load_mat(32'h040, 1, 32'd0);
        run(32'h000, 32'h040, 32'h080, 2, 1'b0);
        check("t5_c21", peek(32 + 9), 32'd9);

        // start coinciding with done is ignored: the 0x200 area stays untouched.
        run(32'h000, 32'h040, 32'h080, 0, 1'b1);
        check("t5_no_start_on_done", peek(128), 32'hFFFF_FFFF);

        // Reset mid-run aborts silently; a fresh run produces the full result.
        load_mat(32'h040, 3, 32'd0);
        a = 32'h000; b = 32'h040; c = 32'h080;
        start = 1'b1;
        done_allowed = 1'b1;
        tick();
        start = 1'b0;
        repeat (200) tick();
        rst = 1'b0;
        done_allowed = 1'b0;
        repeat (3) begin
            tick();
            check("abort_done_low", 32'(done), 32'd0);
        end
        rst = 1'b1;
        repeat (20) tick();
        run(32'h000, 32'h040, 32'h080, 0, 1'b0);

        // Random operands at random non-overlapping 64-byte slots.
        for (int n = 0; n < 4; n++) begin
            int sa, sb, sc;
            sa = $urandom_range(0, 15);
            do sb = $urandom_range(0, 15); while (sb == sa);
            do sc = $urandom_range(0, 15); while (sc == sa || sc == sb);
            load_mat(32'(sa * 64), 3, 32'd0);
            load_mat(32'(sb * 64), 3, 32'd0);
            run(32'(sa * 64), 32'(sb * 64), 32'(sc * 64), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
